// File: rtl/lc3b_control_if.sv
// Shared LC-3b encodings and the control-unit <-> datapath bundle.
// The control unit takes the master side; the datapath takes the slave side.
package lc3b_types;

  typedef enum logic [3:0] {
    op_br   = 4'b0000,
    op_add  = 4'b0001,
    op_ldb  = 4'b0010,
    op_stb  = 4'b0011,
    op_jsr  = 4'b0100,
    op_and  = 4'b0101,
    op_ldr  = 4'b0110,
    op_str  = 4'b0111,
    op_rti  = 4'b1000,
    op_not  = 4'b1001,
    op_ldi  = 4'b1010,
    op_sti  = 4'b1011,
    op_jmp  = 4'b1100,
    op_shf  = 4'b1101,
    op_lea  = 4'b1110,
    op_trap = 4'b1111
  } lc3b_opcode;

  typedef enum logic [1:0] {
    alu_add  = 2'b00,
    alu_and  = 2'b01,
    alu_not  = 2'b10,
    alu_pass = 2'b11
  } lc3b_aluop;

endpackage

interface lc3b_control_if;
  import lc3b_types::*;

  lc3b_opcode opcode;
  logic       instruction5;
  logic       branch_enable;
  logic       mem_resp;

  logic       load_pc;
  logic       load_ir;
  logic       load_regfile;
  logic       load_mar;
  logic       load_mdr;
  logic       load_cc;
  logic [1:0] pcmux_sel;
  logic       marmux_sel;
  logic       mdrmux_sel;
  logic [1:0] alumux_sel;
  logic [1:0] regfilemux_sel;
  logic       storemux_sel;
  lc3b_aluop  aluop;
  logic       mem_read;
  logic       mem_write;
  logic [1:0] mem_byte_enable;

  modport master (
    input  opcode, instruction5, branch_enable, mem_resp,
    output load_pc, load_ir, load_regfile, load_mar, load_mdr, load_cc,
           pcmux_sel, marmux_sel, mdrmux_sel, alumux_sel, regfilemux_sel,
           storemux_sel, aluop, mem_read, mem_write, mem_byte_enable
  );

  modport slave (
    output opcode, instruction5, branch_enable, mem_resp,
    input  load_pc, load_ir, load_regfile, load_mar, load_mdr, load_cc,
           pcmux_sel, marmux_sel, mdrmux_sel, alumux_sel, regfilemux_sel,
           storemux_sel, aluop, mem_read, mem_write, mem_byte_enable
  );

endinterface

// File: rtl/lc3b_control.sv
// Multicycle LC-3b control unit: Moore FSM sequencing fetch, decode and
// per-opcode execute, with memory strobes held until mem_resp.
module lc3b_control
  import lc3b_types::*;
(
  input  logic          clk,
  input  logic          reset,
  lc3b_control_if.master bus
);

  typedef enum logic [3:0] {
    FETCH1, FETCH2, FETCH3, DECODE,
    S_ADD, S_AND, S_NOT, S_BR, S_BR_TAKEN, S_JMP, S_LEA,
    S_CALC_ADDR, LDR1, LDR2, STR1, STR2
  } state_t;

  typedef struct packed {
    logic       load_pc;
    logic       load_ir;
    logic       load_regfile;
    logic       load_mar;
    logic       load_mdr;
    logic       load_cc;
    logic [1:0] pcmux_sel;
    logic       marmux_sel;
    logic       mdrmux_sel;
    logic [1:0] alumux_sel;
    logic [1:0] regfilemux_sel;
    logic       storemux_sel;
    lc3b_aluop  aluop;
    logic       mem_read;
    logic       mem_write;
    logic [1:0] mem_byte_enable;
  } ctrl_t;

  state_t state, next_state;
  ctrl_t  ctrl_q;

  function automatic ctrl_t ctrl_for(state_t s, logic imm);
    ctrl_t c;
    c                 = '0;
    c.aluop           = alu_add;
    c.mem_byte_enable = 2'b11;
    case (s)
      FETCH1:      begin c.marmux_sel = 1'b1; c.load_mar = 1'b1; end
      FETCH2,
      LDR1:        begin c.mem_read = 1'b1; c.mdrmux_sel = 1'b1; c.load_mdr = 1'b1; end
      FETCH3:      begin c.load_ir = 1'b1; c.load_pc = 1'b1; end
      S_ADD,
      S_AND:       begin
                     c.aluop        = (s == S_AND) ? alu_and : alu_add;
                     c.alumux_sel   = imm ? 2'b10 : 2'b00;
                     c.load_regfile = 1'b1;
                     c.load_cc      = 1'b1;
                   end
      S_NOT:       begin c.aluop = alu_not; c.load_regfile = 1'b1; c.load_cc = 1'b1; end
      S_BR_TAKEN:  begin c.pcmux_sel = 2'b01; c.load_pc = 1'b1; end
      S_JMP:       begin c.pcmux_sel = 2'b10; c.load_pc = 1'b1; end
      S_LEA:       begin c.regfilemux_sel = 2'b10; c.load_regfile = 1'b1; c.load_cc = 1'b1; end
      S_CALC_ADDR: begin c.alumux_sel = 2'b01; c.load_mar = 1'b1; end
      LDR2:        begin c.regfilemux_sel = 2'b01; c.load_regfile = 1'b1; c.load_cc = 1'b1; end
      STR1:        begin c.storemux_sel = 1'b1; c.aluop = alu_pass; c.load_mdr = 1'b1; end
      STR2:        c.mem_write = 1'b1;
      default:     ;
    endcase
    return c;
  endfunction

  // opcode is only consulted in DECODE and S_CALC_ADDR, where the IR is stable
  always_comb begin
    next_state = state;
    case (state)
      FETCH1:      next_state = FETCH2;
      FETCH2:      if (bus.mem_resp) next_state = FETCH3;
      FETCH3:      next_state = DECODE;
      DECODE: begin
        case (bus.opcode)
          op_add:  next_state = S_ADD;
          op_and:  next_state = S_AND;
          op_not:  next_state = S_NOT;
          op_br:   next_state = S_BR;
          op_ldr,
          op_str:  next_state = S_CALC_ADDR;
          op_jmp:  next_state = S_JMP;
          op_lea:  next_state = S_LEA;
          default: next_state = FETCH1;
        endcase
      end
      S_BR:        next_state = bus.branch_enable ? S_BR_TAKEN : FETCH1;
      S_CALC_ADDR: next_state = (bus.opcode == op_ldr) ? LDR1 : STR1;
      LDR1:        if (bus.mem_resp) next_state = LDR2;
      STR1:        next_state = STR2;
      STR2:        if (bus.mem_resp) next_state = FETCH1;
      default:     next_state = FETCH1;
    endcase
  end

  // Outputs are registered from the state being entered, so they line up with it
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= FETCH1;
      ctrl_q <= ctrl_for(FETCH1, 1'b0);
    end else begin
      state  <= next_state;
      ctrl_q <= ctrl_for(next_state, bus.instruction5);
    end
  end

  // Enables and strobes are masked by reset so an abort drops them at once
  assign bus.load_pc         = ctrl_q.load_pc      & ~reset;
  assign bus.load_ir         = ctrl_q.load_ir      & ~reset;
  assign bus.load_regfile    = ctrl_q.load_regfile & ~reset;
  assign bus.load_mar        = ctrl_q.load_mar     & ~reset;
  assign bus.load_mdr        = ctrl_q.load_mdr     & ~reset;
  assign bus.load_cc         = ctrl_q.load_cc      & ~reset;
  assign bus.mem_read        = ctrl_q.mem_read     & ~reset;
  assign bus.mem_write       = ctrl_q.mem_write    & ~reset;
  assign bus.pcmux_sel       = ctrl_q.pcmux_sel;
  assign bus.marmux_sel      = ctrl_q.marmux_sel;
  assign bus.mdrmux_sel      = ctrl_q.mdrmux_sel;
  assign bus.alumux_sel      = ctrl_q.alumux_sel;
  assign bus.regfilemux_sel  = ctrl_q.regfilemux_sel;
  assign bus.storemux_sel    = ctrl_q.storemux_sel;
  assign bus.aluop           = ctrl_q.aluop;
  assign bus.mem_byte_enable = ctrl_q.mem_byte_enable;

endmodule

// File: tb/tb_lc3b_control.sv
// Randomized bench for lc3b_control: each instruction is expanded into the
// expected per-cycle control trace and compared with the DUT cycle by cycle.
module tb_lc3b_control;
  import lc3b_types::*;

  typedef struct packed {
    logic       load_pc;
    logic       load_ir;
    logic       load_regfile;
    logic       load_mar;
    logic       load_mdr;
    logic       load_cc;
    logic [1:0] pcmux_sel;
    logic       marmux_sel;
    logic       mdrmux_sel;
    logic [1:0] alumux_sel;
    logic [1:0] regfilemux_sel;
    logic       storemux_sel;
    lc3b_aluop  aluop;
    logic       mem_read;
    logic       mem_write;
    logic [1:0] mem_byte_enable;
  } vec_t;

  typedef struct {
    vec_t v;
    logic resp;
    logic is_write;
  } step_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   vectors = 0;
  int   misses = 0;
  step_t plan[$];

  lc3b_control_if bus();

  lc3b_control dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic vec_t observed();
    vec_t c;
    c.load_pc         = bus.load_pc;
    c.load_ir         = bus.load_ir;
    c.load_regfile    = bus.load_regfile;
    c.load_mar        = bus.load_mar;
    c.load_mdr        = bus.load_mdr;
    c.load_cc         = bus.load_cc;
    c.pcmux_sel       = bus.pcmux_sel;
    c.marmux_sel      = bus.marmux_sel;
    c.mdrmux_sel      = bus.mdrmux_sel;
    c.alumux_sel      = bus.alumux_sel;
    c.regfilemux_sel  = bus.regfilemux_sel;
    c.storemux_sel    = bus.storemux_sel;
    c.aluop           = bus.aluop;
    c.mem_read        = bus.mem_read;
    c.mem_write       = bus.mem_write;
    c.mem_byte_enable = bus.mem_byte_enable;
    return c;
  endfunction

  function automatic vec_t quiet();
    vec_t c;
    c                 = '0;
    c.aluop           = alu_add;
    c.mem_byte_enable = 2'b11;
    return c;
  endfunction

  function automatic vec_t fetch_addr();
    vec_t c;
    c            = quiet();
    c.marmux_sel = 1'b1;
    c.load_mar   = 1'b1;
    return c;
  endfunction

  function automatic logic [7:0] strobes(vec_t c);
    return {c.load_pc, c.load_ir, c.load_regfile, c.load_mar,
            c.load_mdr, c.load_cc, c.mem_read, c.mem_write};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      misses++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Non-memory cycles get a random mem_resp, which must be ignored there
  task automatic push(input vec_t v);
    step_t s;
    s.v        = v;
    s.resp     = 1'($urandom_range(0, 1));
    s.is_write = 1'b0;
    plan.push_back(s);
  endtask

  task automatic pushMem(input vec_t v, input int waits, input logic wr);
    step_t s;
    for (int i = 0; i <= waits; i++) begin
      s.v        = v;
      s.resp     = (i == waits);
      s.is_write = wr;
      plan.push_back(s);
    end
  endtask

  task automatic buildPlan(input logic [3:0] op, input logic imm, input logic be,
                           input int fd, input int md);
    vec_t c;
    plan.delete();
    push(fetch_addr());
    c = quiet(); c.mem_read = 1; c.mdrmux_sel = 1; c.load_mdr = 1;
    pushMem(c, fd, 1'b0);
    c = quiet(); c.load_ir = 1; c.load_pc = 1;
    push(c);
    push(quiet());
    case (op)
      4'd1, 4'd5: begin
        c = quiet(); c.aluop = (op == 4'd5) ? alu_and : alu_add;
        c.alumux_sel = imm ? 2'b10 : 2'b00; c.load_regfile = 1; c.load_cc = 1;
        push(c);
      end
      4'd9: begin
        c = quiet(); c.aluop = alu_not; c.load_regfile = 1; c.load_cc = 1;
        push(c);
      end
      4'd0: begin
        push(quiet());
        if (be) begin
          c = quiet(); c.pcmux_sel = 2'b01; c.load_pc = 1;
          push(c);
        end
      end
      4'd12: begin
        c = quiet(); c.pcmux_sel = 2'b10; c.load_pc = 1;
        push(c);
      end
      4'd14: begin
        c = quiet(); c.regfilemux_sel = 2'b10; c.load_regfile = 1; c.load_cc = 1;
        push(c);
      end
      4'd6, 4'd7: begin
        c = quiet(); c.alumux_sel = 2'b01; c.load_mar = 1;
        push(c);
        if (op == 4'd6) begin
          c = quiet(); c.mem_read = 1; c.mdrmux_sel = 1; c.load_mdr = 1;
          pushMem(c, md, 1'b0);
          c = quiet(); c.regfilemux_sel = 2'b01; c.load_regfile = 1; c.load_cc = 1;
          push(c);
        end else begin
          c = quiet(); c.storemux_sel = 1; c.aluop = alu_pass; c.load_mdr = 1;
          push(c);
          c = quiet(); c.mem_write = 1;
          pushMem(c, md, 1'b1);
        end
      end
      default: ;
    endcase
  endtask

  // Entered with the instruction's first cycle visible; leaves the next one visible
  task automatic applyStimulus(input logic [3:0] op, input logic imm, input logic be,
                               input int fd, input int md, input bit abort);
    bus.opcode        = lc3b_opcode'(op);
    bus.instruction5  = imm;
    bus.branch_enable = be;
    buildPlan(op, imm, be, fd, md);
    for (int k = 0; k < plan.size(); k++) begin
      if (abort && plan[k].is_write) begin
        reset = 1'b1;
        #1;
        checkOutput("reset_drops_strobes", 32'(strobes(observed())), 32'd0);
        #2;
        reset = 1'b0;
        #1;
        checkOutput("fetch1_after_reset", 32'(observed()), 32'(fetch_addr()));
        bus.mem_resp = 1'b0;
        return;
      end
      checkOutput($sformatf("op%0d_cycle%0d", op, k), 32'(observed()), 32'(plan[k].v));
      bus.mem_resp = plan[k].resp;
      @(posedge clk);
      #1;
      bus.mem_resp = 1'b0;
    end
  endtask

  initial begin
    logic [3:0] op;
    bus.opcode        = op_br;
    bus.instruction5  = 1'b0;
    bus.branch_enable = 1'b0;
    bus.mem_resp      = 1'b0;
    reset             = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_state", 32'(strobes(observed())), 32'd0);
    reset = 1'b0;
    #1;

    applyStimulus(4'h1, 1'b1, 1'b0, 3, 0, 1'b0);
    applyStimulus(4'h1, 1'b1, 1'b0, 0, 0, 1'b0);
    applyStimulus(4'h0, 1'b0, 1'b0, 0, 0, 1'b0);
    applyStimulus(4'h0, 1'b0, 1'b1, 0, 0, 1'b0);
    applyStimulus(4'h6, 1'b0, 1'b0, 0, 1, 1'b0);
    applyStimulus(4'h7, 1'b0, 1'b0, 0, 1, 1'b0);
    applyStimulus(4'hD, 1'b0, 1'b0, 0, 0, 1'b0);
    applyStimulus(4'h7, 1'b0, 1'b0, 0, 3, 1'b1);
    applyStimulus(4'h5, 1'b0, 1'b0, 1, 0, 1'b0);

    for (int n = 0; n < 300; n++) begin
      op = 4'($urandom_range(0, 15));
      applyStimulus(op, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                    (op == 4'h7) && ($urandom_range(0, 3) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, misses);
    $finish;
  end

endmodule
